v_lanes_wb: RTL and testbench

Write-back collector directly downstream of the vector lane array. It captures one LMUL register group of lane results (ALU or MUL bank, up to four 128-bit registers) in a single handshake. It then drains the group into the vector register file write port one 128-bit register per cycle, with back-pressure. It signals completion so the issue logic can release the destination register group.

---
 rtl/v_lanes_wb_if.sv | 49 ++++
 rtl/v_lanes_wb.sv | 143 ++++++++++++++
 tb/tb_v_lanes_wb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/v_lanes_wb_if.sv
// Bundle between the lane array, the v_lanes_wb collector and the VRF write port.
// The in_mask member exists only when VWB_MASK_EN is defined.
interface v_lanes_wb_if #(
    parameter int VLEN   = 128,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sel;
    logic [2:0]        in_lmul;
    logic [ADDR_W-1:0] in_vd;
    logic [2:0]        in_vsew;
    logic [VLEN-1:0]   result_valu_1, result_valu_2, result_valu_3, result_valu_4;
    logic [VLEN-1:0]   result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4;
`ifdef VWB_MASK_EN
    logic [63:0]       in_mask;
`endif
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [VLEN-1:0]   wr_data;
    logic [15:0]       wr_be;
    logic              wb_done;
    logic              busy;

    // Collector side
    modport slave (
`ifdef VWB_MASK_EN
        input  in_mask,
`endif
        input  in_valid, in_sel, in_lmul, in_vd, in_vsew,
        input  result_valu_1, result_valu_2, result_valu_3, result_valu_4,
        input  result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4,
        input  wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, wr_be, wb_done, busy
    );

    // Lane array / register file side
    modport master (
`ifdef VWB_MASK_EN
        output in_mask,
`endif
        output in_valid, in_sel, in_lmul, in_vd, in_vsew,
        output result_valu_1, result_valu_2, result_valu_3, result_valu_4,
        output result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4,
        output wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, wr_be, wb_done, busy
    );
endinterface

// File: rtl/v_lanes_wb.sv
// v_lanes_wb: captures one LMUL group of lane results (ALU or MUL bank) and
// drains it into the VRF write port one 128-bit register per accepted write.
// Optional element masking on byte enables: define VWB_MASK_EN.
module v_lanes_wb #(
    parameter int VLEN   = 128,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input logic         clk,
    input logic         rst,
    v_lanes_wb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                 state;
    logic [3:0][VLEN-1:0]   grp_q;
    logic [ADDR_W-1:0]      base_q;
    logic [1:0]             idx_q;
    logic [1:0]             last_q;

    logic [1:0]             lmul_last;
    logic [ADDR_W-1:0]      vd_base;
    logic [VLEN-1:0]        first_data;
    logic [1:0]             idx_nx;
    logic [ADDR_W-1:0]      addr_nx;
    logic [15:0]            be_first;
    logic [15:0]            be_nx;

`ifdef VWB_MASK_EN
    logic [2:0]             vsew_q;
    logic [63:0]            mask_q;

    // Byte enables of group register r: each element's bytes follow its mask bit.
    function automatic logic [15:0] be_of(input logic [63:0] m, input logic [2:0] sew,
                                          input logic [1:0] r);
        logic [15:0] be;
        int          bit_i;
        be = '0;
        for (int b = 0; b < 16; b++) begin
            case (sew)
                3'b000:  bit_i = int'(r) * 16 + b;
                3'b001:  bit_i = int'(r) * 8 + b / 2;
                default: bit_i = int'(r) * 4 + b / 4;
            endcase
            be[b] = m[bit_i];
        end
        return be;
    endfunction
`endif

    // Accept-side decode and next-register selection for the drain.
    always_comb begin
        case (bus.in_lmul)
            3'b001:  lmul_last = 2'd1;
            3'b010:  lmul_last = 2'd3;
            default: lmul_last = 2'd0;
        endcase
        // Misaligned vd is forced down to the group alignment.
        vd_base    = bus.in_vd & ~ADDR_W'(lmul_last);
        first_data = bus.in_sel ? bus.result_vmul_1 : bus.result_valu_1;
        idx_nx     = idx_q + 2'd1;
        // Alignment keeps this below NREG; the modulo only documents the range.
        addr_nx    = ADDR_W'((32'(base_q) + 32'(idx_nx)) % NREG);
`ifdef VWB_MASK_EN
        be_first   = be_of(bus.in_mask, bus.in_vsew, 2'd0);
        be_nx      = be_of(mask_q, vsew_q, idx_nx);
`else
        be_first   = 16'hFFFF;
        be_nx      = 16'hFFFF;
`endif
    end

    // FSM with registered outputs: capture in IDLE, drain in WRITE, pulse in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grp_q        <= '0;
            base_q       <= '0;
            idx_q        <= '0;
            last_q       <= '0;
`ifdef VWB_MASK_EN
            vsew_q       <= '0;
            mask_q       <= '0;
`endif
            bus.in_ready <= 1'b1;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.wr_be    <= '0;
            bus.wb_done  <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        grp_q <= bus.in_sel
                            ? {bus.result_vmul_4, bus.result_vmul_3, bus.result_vmul_2, bus.result_vmul_1}
                            : {bus.result_valu_4, bus.result_valu_3, bus.result_valu_2, bus.result_valu_1};
                        base_q       <= vd_base;
                        last_q       <= lmul_last;
                        idx_q        <= '0;
`ifdef VWB_MASK_EN
                        vsew_q       <= bus.in_vsew;
                        mask_q       <= bus.in_mask;
`endif
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.wr_en    <= 1'b1;
                        bus.wr_addr  <= vd_base;
                        bus.wr_data  <= first_data;
                        bus.wr_be    <= be_first;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    // Without wr_ready every write output simply holds.
                    if (bus.wr_ready) begin
                        if (idx_q == last_q) begin
                            bus.wr_en   <= 1'b0;
                            bus.wr_addr <= '0;
                            bus.wr_data <= '0;
                            bus.wr_be   <= '0;
                            bus.wb_done <= 1'b1;
                            state       <= DONE;
                        end else begin
                            idx_q       <= idx_nx;
                            bus.wr_addr <= addr_nx;
                            bus.wr_data <= grp_q[idx_nx];
                            bus.wr_be   <= be_nx;
                        end
                    end
                end
                DONE: begin
                    bus.wb_done  <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v_lanes_wb.sv
// Directed + randomized bench for v_lanes_wb with a transaction-level model.
module tb_v_lanes_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    v_lanes_wb_if #(.VLEN(128), .ADDR_W(5)) bus();
    v_lanes_wb #(.VLEN(128), .NREG(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected byte enables for group register r, from element size and mask.
    function automatic logic [15:0] exp_be(input logic [2:0] sew, input logic [63:0] m, input int r);
        logic [15:0] be;
        int esz;
        be = 16'hFFFF;
`ifdef VWB_MASK_EN
        esz = (sew == 3'd0) ? 1 : (sew == 3'd1) ? 2 : 4;
        for (int b = 0; b < 16; b++) be[b] = m[r * (16 / esz) + b / esz];
`endif
        return be;
    endfunction

    task automatic scramble_inputs();
        bus.in_sel  = 1'($urandom);
        bus.in_lmul = 3'($urandom);
        bus.in_vd   = 5'($urandom);
        bus.in_vsew = 3'($urandom);
        bus.result_valu_1 = rnd128(); bus.result_valu_2 = rnd128();
        bus.result_valu_3 = rnd128(); bus.result_valu_4 = rnd128();
        bus.result_vmul_1 = rnd128(); bus.result_vmul_2 = rnd128();
        bus.result_vmul_3 = rnd128(); bus.result_vmul_4 = rnd128();
`ifdef VWB_MASK_EN
        bus.in_mask = {$urandom, $urandom};
`endif
    endtask

    // One group, starting at a negedge with the DUT idle.
    // rmode: 0 always ready, 1 random ready, 2 stalled for the first two WRITE cycles.
    // abort_at > 0: assert rst once that many writes have been accepted.
    task automatic run_group(input logic sel, input logic [2:0] lmul, input logic [4:0] vd,
                             input logic [2:0] sew, input logic [63:0] mask,
                             input logic [127:0] d0, input int rmode, input int abort_at,
                             input bit junk);
        logic [127:0] d [4];
        int n, base, idx, cyc;
        logic rdy;
        n    = (lmul == 3'b001) ? 2 : (lmul == 3'b010) ? 4 : 1;
        base = (int'(vd) / n) * n;
        d[0] = d0;
        for (int i = 1; i < 4; i++) d[i] = rnd128();
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);
        scramble_inputs();
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_lmul  = lmul;
        bus.in_vd    = vd;
        bus.in_vsew  = sew;
`ifdef VWB_MASK_EN
        bus.in_mask  = mask;
`endif
        if (sel) begin
            bus.result_vmul_1 = d[0]; bus.result_vmul_2 = d[1];
            bus.result_vmul_3 = d[2]; bus.result_vmul_4 = d[3];
        end else begin
            bus.result_valu_1 = d[0]; bus.result_valu_2 = d[1];
            bus.result_valu_3 = d[2]; bus.result_valu_4 = d[3];
        end
        @(negedge clk);
        if (junk) scramble_inputs(); else bus.in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 100) begin
            chk("wr_en", 128'(bus.wr_en), 128'd1);
            chk("wr_addr", 128'(bus.wr_addr), 128'(base + idx));
            chk("wr_data", bus.wr_data, d[idx]);
            chk("wr_be", 128'(bus.wr_be), 128'(exp_be(sew, mask, idx)));
            chk("in_ready_busy", {126'd0, bus.in_ready, bus.busy}, 128'd1);
            chk("wb_done_early", 128'(bus.wb_done), 128'd0);
            if (abort_at > 0 && idx == abort_at) begin
                rst = 1'b1;
                bus.wr_ready = 1'b1;
                bus.in_valid = 1'b0;
                @(negedge clk);
                chk("abort_wr_en", 128'(bus.wr_en), 128'd0);
                chk("abort_wb_done", 128'(bus.wb_done), 128'd0);
                rst = 1'b0;
                @(negedge clk);
                chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
                chk("abort_quiet", {125'd0, bus.wr_en, bus.wb_done, bus.busy}, 128'd0);
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                2:       rdy = (cyc >= 2);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.wr_ready = rdy;
            if (junk) scramble_inputs();
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        chk("drain_bound", 128'(idx), 128'(n));
        chk("done_pulse", {125'd0, bus.wr_en, bus.wb_done, bus.busy}, 128'b011);
        chk("done_in_ready", 128'(bus.in_ready), 128'd0);
        if (junk) scramble_inputs();
        @(negedge clk);
        chk("post_idle", {124'd0, bus.in_ready, bus.wr_en, bus.wb_done, bus.busy}, 128'b1000);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] k;
        scramble_inputs();
        bus.in_valid = 1'b1;   // must be ignored during reset
        bus.wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outs", {bus.wr_en, bus.wr_addr, bus.wr_be, bus.wb_done, bus.busy}, 128'd0);
        chk("rst_wr_data", bus.wr_data, 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("first_idle", {126'd0, bus.in_ready, bus.wr_en}, 128'b10);

        k = 128'h0123456789ABCDEF0123456789ABCDEF;
        run_group(1'b0, 3'b000, 5'd5, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, k, 0, 0, 1'b0);
        run_group(1'b1, 3'b010, 5'd9, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, rnd128(), 0, 0, 1'b0);
        run_group(1'b0, 3'b001, 5'd3, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, rnd128(), 2, 0, 1'b0);
        run_group(1'b1, 3'b010, 5'd17, 3'b000, {$urandom, $urandom}, rnd128(), 1, 0, 1'b1);
        run_group(1'b0, 3'b001, 5'd30, 3'b010, {$urandom, $urandom}, rnd128(), 0, 0, 1'b0);
        run_group(1'b0, 3'b010, 5'd12, 3'b010, {$urandom, $urandom}, rnd128(), 0, 2, 1'b0);
        run_group(1'b1, 3'b010, 5'd28, 3'b001, {$urandom, $urandom}, rnd128(), 0, 0, 1'b0);
        run_group(1'b0, 3'b001, 5'd6, 3'b010, 64'h5A, rnd128(), 0, 0, 1'b0);
        run_group(1'b1, 3'b000, 5'd1, 3'b000, 64'hFFFF, rnd128(), 0, 0, 1'b0);
        run_group(1'b0, 3'b111, 5'd31, 3'b101, {$urandom, $urandom}, rnd128(), 0, 0, 1'b0);

        for (int g = 0; g < 40; g++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("gap_idle", {126'd0, bus.in_ready, bus.wr_en}, 128'b10);
                end
            end
            run_group(1'($urandom), 3'($urandom), 5'($urandom), 3'($urandom),
                      {$urandom, $urandom}, rnd128(), 1,
                      ($urandom_range(0, 7) == 0) ? 1 : 0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
